// File: rtl/ads8528_emu_pkg.sv
// Shared types and constants for the ADS8528 parallel-mode responder model.
package ads8528_emu_pkg;

  typedef enum logic {IDLE = 1'b0, CONVERTING = 1'b1} state_t;

  localparam int NUM_CH   = 8;
  localparam int SAMPLE_W = 16;
  localparam int FRAME_W  = 13;

  localparam int ERR_CS_MISMATCH = 0;
  localparam int ERR_CS_BUSY     = 1;
  localparam int ERR_RD_BUSY     = 2;
  localparam int ERR_RD_OVERRUN  = 3;

  localparam logic [15:0] CFG_HI = 16'h8054;
  localparam logic [15:0] CFG_LO = 16'h43FF;

  // Sample word: channel number in the top bits, frame count below.
  function automatic logic [SAMPLE_W-1:0] make_sample(input logic [2:0] ch,
                                                      input logic [FRAME_W-1:0] frame);
    return {ch, frame};
  endfunction

endpackage

// File: rtl/ads8528_emu_proto_check.sv
// Sticky protocol-violation flags for the ADS8528 responder.
module ads8528_emu_proto_check
  import ads8528_emu_pkg::*;
(
  input  logic       clk,
  input  logic       sreset,
  input  logic       active,
  input  logic [3:0] conv_start,
  input  logic       cs_rise,
  input  logic       converting,
  input  logic       busy,
  input  logic       read_fall,
  input  logic       done,
  output logic [3:0] proto_err
);

  logic [3:0] rd_since;

  // Flag capture plus a saturating count of reads since the last completed frame.
  always_ff @(posedge clk) begin
    if (sreset) begin
      proto_err <= 4'h0;
      rd_since  <= 4'h0;
    end else begin
      if (active && !((&conv_start) || (~|conv_start))) proto_err[ERR_CS_MISMATCH] <= 1'b1;
      if (cs_rise && converting)                        proto_err[ERR_CS_BUSY]     <= 1'b1;
      if (read_fall && busy)                            proto_err[ERR_RD_BUSY]     <= 1'b1;
      if (read_fall && (rd_since == 4'd8))              proto_err[ERR_RD_OVERRUN]  <= 1'b1;
      if (done)
        rd_since <= 4'h0;
      else if (read_fall && (rd_since != 4'd9))
        rd_since <= rd_since + 4'd1;
    end
  end

endmodule

// File: rtl/ads8528_emulator.sv
// ADS8528 parallel-mode responder: config capture, timed conversions, sequential reads.
// Define ADS_EMU_PROTO_CHECK_EN to build the sticky protocol-error checker.
module ads8528_emulator
  import ads8528_emu_pkg::*;
#(
  parameter int CONV_CYCLES = 12
) (
  input  logic        clk,
  input  logic        sreset,
  input  logic        chipselect_n,
  input  logic        write_n,
  input  logic        read_n,
  input  logic        software_mode,
  input  logic        serial_mode,
  input  logic        standby_n,
  input  logic        conv_start_a,
  input  logic        conv_start_b,
  input  logic        conv_start_c,
  input  logic        conv_start_d,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_oe,
  output logic        busy,
  output logic [31:0] cfg_reg,
  output logic        cfg_valid,
  output logic [3:0]  proto_err
);

  localparam logic [7:0] CNT_LOAD = 8'(CONV_CYCLES - 1);

  logic active, cs_any;
  logic write_q, read_q, cs_q;
  logic write_rise, read_rise, cs_rise;
  state_t state, next_state;
  logic [7:0] cnt, next_cnt;
  logic done;
  logic wr_half;
  logic [2:0] rd_ptr;
  logic [FRAME_W-1:0] frame_cnt;
  logic [SAMPLE_W-1:0] sample [NUM_CH];

  assign active     = software_mode & ~serial_mode & standby_n;
  assign cs_any     = conv_start_a | conv_start_b | conv_start_c | conv_start_d;
  assign write_rise = write_n & ~write_q;
  assign read_rise  = read_n & ~read_q;
  assign cs_rise    = cs_any & ~cs_q;

  // Edge-detect history; keeps tracking through reset so no false edge follows it.
  always_ff @(posedge clk) begin
    write_q <= write_n;
    read_q  <= read_n;
    cs_q    <= cs_any;
  end

  // Conversion sequencing; completion happens in the cycle the counter is zero.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (cs_rise && active) begin
          next_state = CONVERTING;
          next_cnt   = CNT_LOAD;
        end else begin
          next_state = IDLE;
        end
      end
      CONVERTING: begin
        if (cnt == 8'd0) begin
          done       = 1'b1;
          next_state = IDLE;
        end else begin
          next_cnt = cnt - 8'd1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // FSM state, down-counter and busy output.
  always_ff @(posedge clk) begin
    if (sreset) begin
      state <= IDLE;
      cnt   <= 8'd0;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      busy  <= (next_state == CONVERTING);
    end
  end

  // Two-half config register capture on write strobe release.
  always_ff @(posedge clk) begin
    if (sreset) begin
      cfg_reg   <= 32'h0;
      cfg_valid <= 1'b0;
      wr_half   <= 1'b0;
    end else begin
      cfg_valid <= 1'b0;
      if (write_rise && !chipselect_n && active) begin
        if (wr_half) begin
          cfg_reg[15:0] <= data_in;
          cfg_valid     <= 1'b1;
        end else begin
          cfg_reg[31:16] <= data_in;
        end
        wr_half <= ~wr_half;
      end
    end
  end

  // Sample bank refresh on completion; completion overrides a coincident read advance.
  always_ff @(posedge clk) begin
    if (sreset) begin
      frame_cnt <= '0;
      rd_ptr    <= 3'd0;
      for (int k = 0; k < NUM_CH; k++) sample[k] <= 16'h0000;
    end else if (done) begin
      for (int k = 0; k < NUM_CH; k++) sample[k] <= make_sample(3'(k), frame_cnt);
      frame_cnt <= frame_cnt + 13'd1;
      rd_ptr    <= 3'd0;
    end else if (read_rise) begin
      rd_ptr <= rd_ptr + 3'd1;
    end
  end

  assign data_oe  = ~chipselect_n & ~read_n & active;
  assign data_out = data_oe ? sample[rd_ptr] : 16'h0000;

`ifdef ADS_EMU_PROTO_CHECK_EN
  logic read_fall;
  assign read_fall = ~read_n & read_q;

  ads8528_emu_proto_check u_proto_check (
    .clk        (clk),
    .sreset     (sreset),
    .active     (active),
    .conv_start ({conv_start_d, conv_start_c, conv_start_b, conv_start_a}),
    .cs_rise    (cs_rise),
    .converting (state == CONVERTING),
    .busy       (busy),
    .read_fall  (read_fall),
    .done       (done),
    .proto_err  (proto_err)
  );
`else
  assign proto_err = 4'h0;
`endif

endmodule

// File: tb/tb_ads8528_emulator.sv
// Scoreboard bench for ads8528_emulator; a second short-conversion instance covers frame wrap.
module tb_ads8528_emulator;

  logic        clk = 1'b0;
  logic        sreset, chipselect_n, write_n, read_n;
  logic        software_mode, serial_mode, standby_n;
  logic [3:0]  cs_vec;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_oe, busy, cfg_valid;
  logic [31:0] cfg_reg;
  logic [3:0]  proto_err;

  logic [3:0]  cs_vec2;
  logic        read_n2;
  logic [15:0] data_out2;
  logic        data_oe2, busy2, cfg_valid2;
  logic [31:0] cfg_reg2;
  logic [3:0]  proto_err2;

  always #5 clk = ~clk;

  ads8528_emulator #(.CONV_CYCLES(12)) dut (
    .clk(clk), .sreset(sreset), .chipselect_n(chipselect_n), .write_n(write_n),
    .read_n(read_n), .software_mode(software_mode), .serial_mode(serial_mode),
    .standby_n(standby_n), .conv_start_a(cs_vec[0]), .conv_start_b(cs_vec[1]),
    .conv_start_c(cs_vec[2]), .conv_start_d(cs_vec[3]), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .busy(busy), .cfg_reg(cfg_reg),
    .cfg_valid(cfg_valid), .proto_err(proto_err)
  );

  ads8528_emulator #(.CONV_CYCLES(1)) dut_wrap (
    .clk(clk), .sreset(sreset), .chipselect_n(chipselect_n), .write_n(1'b1),
    .read_n(read_n2), .software_mode(software_mode), .serial_mode(serial_mode),
    .standby_n(standby_n), .conv_start_a(cs_vec2[0]), .conv_start_b(cs_vec2[1]),
    .conv_start_c(cs_vec2[2]), .conv_start_d(cs_vec2[3]), .data_in(16'h0000),
    .data_out(data_out2), .data_oe(data_oe2), .busy(busy2), .cfg_reg(cfg_reg2),
    .cfg_valid(cfg_valid2), .proto_err(proto_err2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int valid_pulses = 0;

  logic [15:0] exp_q[$];
  int frames;
  bit have_frame;
  int rd_ptr_m;

  always @(negedge clk) if (cfg_valid === 1'b1) valid_pulses++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_sample();
    logic [2:0]  ch;
    logic [12:0] f;
    ch = rd_ptr_m[2:0];
    f  = 13'(frames - 1);
    return have_frame ? {ch, f} : 16'h0000;
  endfunction

  task automatic model_reset();
    frames = 0;
    have_frame = 1'b0;
    rd_ptr_m = 0;
  endtask

  task automatic do_reset();
    sreset = 1'b1;
    sync();
    sync();
    sreset = 1'b0;
    model_reset();
  endtask

  task automatic do_write(input logic [15:0] v);
    data_in = v;
    write_n = 1'b0;
    sync();
    write_n = 1'b1;
    sync();
    sync();
  endtask

  task automatic do_read(input string tag, input bit exp_oe);
    exp_q.push_back(exp_oe ? model_sample() : 16'h0000);
    read_n = 1'b0;
    @(negedge clk);
    check_eq({tag, "_oe"}, data_oe, exp_oe);
    if (exp_q.size() == 0) check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
    else check_eq(tag, data_out, exp_q.pop_front());
    sync();
    read_n = 1'b1;
    sync();
    rd_ptr_m = (rd_ptr_m + 1) % 8;
  endtask

  task automatic do_conv(input string tag);
    int busy_len;
    cs_vec = 4'hF;
    sync();
    cs_vec = 4'h0;
    busy_len = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      busy_len++;
    end
    check_eq(tag, busy_len, 12);
    sync();
    frames++;
    have_frame = 1'b1;
    rd_ptr_m = 0;
  endtask

  initial begin
    int busy_len;
    int seen_busy, seen_oe;
    chipselect_n = 1'b0; write_n = 1'b1; read_n = 1'b1; read_n2 = 1'b1;
    software_mode = 1'b1; serial_mode = 1'b0; standby_n = 1'b1;
    cs_vec = 4'h0; cs_vec2 = 4'h0; data_in = 16'h0000; sreset = 1'b0;
    model_reset();

    // 1: reset state and config capture
    do_reset();
    @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_cfg", cfg_reg, 32'h0);
    check_eq("rst_valid", cfg_valid, 1'b0);
    check_eq("rst_err", proto_err, 4'h0);
    check_eq("rst_oe", data_oe, 1'b0);
    sync();
    begin
      int p0;
      p0 = valid_pulses;
      do_write(16'h8054);
      do_write(16'h43FF);
      check_eq("cfg_reg", cfg_reg, 32'h805443FF);
      check_eq("cfg_pulses", valid_pulses - p0, 1);
      check_eq("cfg_err", proto_err, 4'h0);
    end

    // 2/3: two conversions, eight reads each
    do_conv("busy_len1");
    for (int k = 0; k < 8; k++) do_read($sformatf("rd1_ch%0d", k), 1'b1);
    do_conv("busy_len2");
    for (int k = 0; k < 8; k++) do_read($sformatf("rd2_ch%0d", k), 1'b1);
    check_eq("clean_err", proto_err, 4'h0);

    // 4: restart attempt and read mid-busy
    do_reset();
    do_conv("busy_len3");
    do_conv("busy_len4");
    cs_vec = 4'hF;
    sync();
    cs_vec = 4'h0;
    busy_len = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) cs_vec = 4'hF;
      if (i == 4) cs_vec = 4'h0;
      if (i == 5) begin
        exp_q.push_back(model_sample());
        read_n = 1'b0;
      end
      if (i == 6) read_n = 1'b1;
      @(negedge clk);
      if (i == 5) begin
        check_eq("midbusy_oe", data_oe, 1'b1);
        check_eq("midbusy_rd", data_out, exp_q.pop_front());
      end
      if (busy !== 1'b1) break;
      busy_len++;
      sync();
    end
    check_eq("busy_len_restart", busy_len, 12);
    sync();
    frames++;
    rd_ptr_m = 0;
`ifdef ADS_EMU_PROTO_CHECK_EN
    check_eq("err_midbusy", proto_err, 4'b0110);
`else
    check_eq("err_midbusy", proto_err, 4'b0000);
`endif

    // 5: standby ignores conversions and releases the bus
    standby_n = 1'b0;
    cs_vec = 4'hF;
    sync();
    cs_vec = 4'h0;
    seen_busy = 0;
    seen_oe = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) seen_busy++;
      if (data_oe !== 1'b0) seen_oe++;
      sync();
    end
    check_eq("standby_busy", seen_busy, 0);
    check_eq("standby_oe", seen_oe, 0);
    do_read("standby_rd", 1'b0);
    standby_n = 1'b1;
    sync();
    do_conv("busy_len5");
    for (int k = 0; k < 9; k++) do_read($sformatf("rd9_%0d", k), 1'b1);
`ifdef ADS_EMU_PROTO_CHECK_EN
    check_eq("err_overrun", proto_err, 4'b1110);
`else
    check_eq("err_overrun", proto_err, 4'b0000);
`endif

    // 6: reset mid-conversion
    cs_vec = 4'hF;
    sync();
    cs_vec = 4'h0;
    for (int i = 0; i < 4; i++) sync();
    sreset = 1'b1;
    sync();
    sreset = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("abort_busy", busy, 1'b0);
    sync();
    seen_busy = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) seen_busy++;
      sync();
    end
    check_eq("abort_no_busy", seen_busy, 0);
    check_eq("abort_cfg", cfg_reg, 32'h0);
    check_eq("abort_err", proto_err, 4'h0);
    do_read("abort_rd0", 1'b1);
    do_read("abort_rd1", 1'b1);

    // frame counter wrap on the short-conversion instance
    for (int n = 0; n < 8192; n++) begin
      cs_vec2 = 4'hF;
      sync();
      cs_vec2 = 4'h0;
      sync();
    end
    sync();
    read_n2 = 1'b0;
    @(negedge clk);
    check_eq("wrap_last", data_out2, 16'h1FFF);
    sync();
    read_n2 = 1'b1;
    sync();
    cs_vec2 = 4'hF;
    sync();
    cs_vec2 = 4'h0;
    sync();
    sync();
    read_n2 = 1'b0;
    @(negedge clk);
    check_eq("wrap_zero", data_out2, 16'h0000);
    check_eq("wrap_busy", busy2, 1'b0);
    sync();
    read_n2 = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
